// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
//   Shared definitions for the execute stage and its EX/MEM register:
//   default widths, ALU operation encodings and the multiply-sequencing
//   FSM state type.
package ex_mem_stage_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ex_mem_stage_mul_iter.sv
// ex_mem_stage_mul_iter
//   Iterative shift-add multiplier: one partial product per clock,
//   DATA_W steps. Produces the low DATA_W bits of the unsigned product.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          load operands, clear accumulator and step counter
//   abort          cancel an operation in progress (wins over start)
//   multiplicand   operand A, sampled on start
//   multiplier     operand B, sampled on start
//   busy           steps remain to be executed
//   done           the final step executes at the coming edge; product is
//                  valid in the cycle after done
//   product        accumulator contents
module ex_mem_stage_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0] mplier_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
    end else if (abort) begin
      count_reg <= '0;
      busy_reg  <= 1'b0;
    end else if (start) begin
      mcand_reg  <= multiplicand;
      mplier_reg <= multiplier;
      acc_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      // Bits shifted past the MSB of the multiplicand only affect the
      // discarded high half of the product.
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
      if (count_reg == LAST_STEP) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = busy_reg && (count_reg == LAST_STEP);
  assign product = acc_reg;

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Execute stage plus EX/MEM pipeline register. Computes the ALU result,
//   destination register and branch target/taken from ID/EX contents and
//   registers them for MEM. MUL runs on an iterative multiplier; while it
//   runs, stall holds ID/EX and the output register carries bubbles.
// Optional build macro:
//   EX_OVF_TRAP_EN  adds registered output ovf (signed add/sub overflow)
//                   and suppresses RegWrite for the overflowing op.
// Ports:
//   clk, rst, flush                      clock, async reset, squash
//   in_instr_bits_15_11 / _20_16         rd / rt specifiers
//   in_extended_bits                     sign-extended immediate
//   in_read_data1 / in_read_data2        rs / rt operands
//   in_new_pc_value                      PC+4
//   in_RegDst .. in_Branch, in_load_mode control from ID/EX
//   in_ALUOp                             operation select
//   stall                                hold ID/EX
//   alu_result, write_data, dest_reg,
//   branch_target, branch_taken,
//   RegWrite, MemWrite, MemRead,
//   MemToReg, load_mode                  EX/MEM register contents
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] in_instr_bits_15_11,
  input  logic [REG_ADDR_W-1:0] in_instr_bits_20_16,
  input  logic [DATA_W-1:0]     in_extended_bits,
  input  logic [DATA_W-1:0]     in_read_data1,
  input  logic [DATA_W-1:0]     in_read_data2,
  input  logic [DATA_W-1:0]     in_new_pc_value,
  input  logic                  in_RegDst,
  input  logic                  in_RegWrite,
  input  logic                  in_ALUSrc,
  input  logic                  in_MemWrite,
  input  logic                  in_MemRead,
  input  logic                  in_MemToReg,
  input  logic                  in_Branch,
  input  logic [1:0]            in_load_mode,
  input  logic [2:0]            in_ALUOp,
  output logic                  stall,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     write_data,
  output logic [REG_ADDR_W-1:0] dest_reg,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  branch_taken,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  MemToReg,
`ifdef EX_OVF_TRAP_EN
  output logic                  ovf,
`endif
  output logic [1:0]            load_mode
);

  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     alu_value;
  logic [DATA_W-1:0]     target_value;
  logic [REG_ADDR_W-1:0] dest_value;
  logic                  reg_write_value;

  logic [DATA_W-1:0]     product;
  logic                  mul_start;
  logic                  mul_busy;
  logic                  mul_done;

  state_t                state_reg;
  state_t                state_next;
  logic                  commit_alu;
  logic                  commit_mul;

  assign op_b         = in_ALUSrc ? in_extended_bits : in_read_data2;
  assign dest_value   = in_RegDst ? in_instr_bits_15_11 : in_instr_bits_20_16;
  assign target_value = in_new_pc_value + {in_extended_bits[DATA_W-3:0], 2'b00};

  always_comb begin
    alu_value = '0;
    case (in_ALUOp)
      ALU_ADD: alu_value = in_read_data1 + op_b;
      ALU_SUB: alu_value = in_read_data1 - op_b;
      ALU_AND: alu_value = in_read_data1 & op_b;
      ALU_OR:  alu_value = in_read_data1 | op_b;
      ALU_SLT: alu_value = {{(DATA_W-1){1'b0}},
                            ($signed(in_read_data1) < $signed(op_b))};
      ALU_NOR: alu_value = ~(in_read_data1 | op_b);
      ALU_SLL: alu_value = op_b << in_extended_bits[10:6];
      // Product comes from the multiplier, not from this path.
      ALU_MUL: alu_value = '0;
      default: alu_value = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  logic ovf_value;

  // Signed overflow: operands (B inverted for sub) share a sign that
  // differs from the result's sign.
  always_comb begin
    ovf_value = 1'b0;
    if (in_ALUOp == ALU_ADD) begin
      ovf_value = (in_read_data1[DATA_W-1] == op_b[DATA_W-1]) &&
                  (alu_value[DATA_W-1] != in_read_data1[DATA_W-1]);
    end else if (in_ALUOp == ALU_SUB) begin
      ovf_value = (in_read_data1[DATA_W-1] != op_b[DATA_W-1]) &&
                  (alu_value[DATA_W-1] != in_read_data1[DATA_W-1]);
    end
  end

  assign reg_write_value = in_RegWrite & ~ovf_value;
`else
  assign reg_write_value = in_RegWrite;
`endif

  ex_mem_stage_mul_iter #(
    .DATA_W(DATA_W)
  ) u_mul_iter (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .abort        (flush),
    .multiplicand (in_read_data1),
    .multiplier   (op_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sequencing: stall is raised combinationally in the accepting IDLE
  // cycle and throughout BUSY, so ID/EX holds the mul until DONE commits.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    mul_start  = 1'b0;
    commit_alu = 1'b0;
    commit_mul = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          state_next = IDLE;
        end else if (in_ALUOp == ALU_MUL) begin
          state_next = BUSY;
          stall      = 1'b1;
          mul_start  = 1'b1;
        end else begin
          commit_alu = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else if (mul_done) begin
          state_next = DONE;
        end else if (!mul_busy) begin
          // Multiplier lost its operation; recover rather than hang.
          state_next = IDLE;
        end
      end
      DONE: begin
        state_next = IDLE;
        commit_mul = !flush;
      end
      default: state_next = IDLE;
    endcase
  end

  // EX/MEM register. Any cycle without a commit is a bubble: control
  // fields clear, data fields keep their previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result    <= '0;
      write_data    <= '0;
      dest_reg      <= '0;
      branch_target <= '0;
      branch_taken  <= 1'b0;
      RegWrite      <= 1'b0;
      MemWrite      <= 1'b0;
      MemRead       <= 1'b0;
      MemToReg      <= 1'b0;
      load_mode     <= '0;
    end else begin
      branch_taken <= 1'b0;
      RegWrite     <= 1'b0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
      MemToReg     <= 1'b0;
      load_mode    <= '0;
      if (commit_alu || commit_mul) begin
        alu_result    <= commit_mul ? product : alu_value;
        write_data    <= in_read_data2;
        dest_reg      <= dest_value;
        branch_target <= target_value;
        branch_taken  <= commit_alu && in_Branch && (alu_value == '0);
        RegWrite      <= reg_write_value;
        MemWrite      <= in_MemWrite;
        MemRead       <= in_MemRead;
        MemToReg      <= in_MemToReg;
        load_mode     <= in_load_mode;
      end
    end
  end

`ifdef EX_OVF_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= commit_alu && ovf_value;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
//   Scoreboard bench for ex_mem_stage: each transaction's expected EX/MEM
//   contents are queued when driven and compared when the register loads.
//   Build with EX_OVF_TRAP_EN defined to exercise the overflow trap too.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [AW-1:0] dest;
    logic [DW-1:0] bt;
    logic          taken;
    logic          rw;
    logic          mw;
    logic          mr;
    logic          m2r;
    logic [1:0]    lm;
  } obs_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [AW-1:0] rd;
  logic [AW-1:0] rt;
  logic [DW-1:0] ext;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] npc;
  logic          reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch;
  logic [1:0]    lmode;
  logic [2:0]    alu_op;

  logic          stall;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] write_data;
  logic [AW-1:0] dest_reg;
  logic [DW-1:0] branch_target;
  logic          branch_taken;
  logic          RegWrite, MemWrite, MemRead, MemToReg;
  logic [1:0]    load_mode;
`ifdef EX_OVF_TRAP_EN
  logic          ovf;
`endif

  int   checks;
  int   fails;
  obs_t sb[$];
  obs_t last_commit;
  obs_t got;
  obs_t exp_v;

  ex_mem_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .in_instr_bits_15_11 (rd),
    .in_instr_bits_20_16 (rt),
    .in_extended_bits    (ext),
    .in_read_data1       (rd1),
    .in_read_data2       (rd2),
    .in_new_pc_value     (npc),
    .in_RegDst           (reg_dst),
    .in_RegWrite         (reg_write),
    .in_ALUSrc           (alu_src),
    .in_MemWrite         (mem_write),
    .in_MemRead          (mem_read),
    .in_MemToReg         (mem_to_reg),
    .in_Branch           (branch),
    .in_load_mode        (lmode),
    .in_ALUOp            (alu_op),
    .stall               (stall),
    .alu_result          (alu_result),
    .write_data          (write_data),
    .dest_reg            (dest_reg),
    .branch_target       (branch_target),
    .branch_taken        (branch_taken),
    .RegWrite            (RegWrite),
    .MemWrite            (MemWrite),
    .MemRead             (MemRead),
    .MemToReg            (MemToReg),
`ifdef EX_OVF_TRAP_EN
    .ovf                 (ovf),
`endif
    .load_mode           (load_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.alu   = alu_result;
    o.wd    = write_data;
    o.dest  = dest_reg;
    o.bt    = branch_target;
    o.taken = branch_taken;
    o.rw    = RegWrite;
    o.mw    = MemWrite;
    o.mr    = MemRead;
    o.m2r   = MemToReg;
    o.lm    = load_mode;
    return o;
  endfunction

  // Reference model of the committed EX/MEM contents for current inputs.
  function automatic obs_t model();
    obs_t          e;
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    logic [4:0]    sh;
    b  = alu_src ? ext : rd2;
    sh = ext[10:6];
    r  = '0;
    case (alu_op)
      3'd0: r = rd1 + b;
      3'd1: r = rd1 - b;
      3'd2: r = rd1 & b;
      3'd3: r = rd1 | b;
      3'd4: r = ($signed(rd1) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: r = ~(rd1 | b);
      3'd6: r = b << sh;
      default: r = rd1 * b;
    endcase
    e.alu   = r;
    e.wd    = rd2;
    e.dest  = reg_dst ? rd : rt;
    e.bt    = npc + (ext << 2);
    e.taken = (alu_op != 3'd7) && branch && (r == 32'd0);
    e.rw    = reg_write;
    e.mw    = mem_write;
    e.mr    = mem_read;
    e.m2r   = mem_to_reg;
    e.lm    = lmode;
`ifdef EX_OVF_TRAP_EN
    if ((alu_op == 3'd0 && rd1[31] == b[31] && r[31] != rd1[31]) ||
        (alu_op == 3'd1 && rd1[31] != b[31] && r[31] != rd1[31]))
      e.rw = 1'b0;
`endif
    return e;
  endfunction

  function automatic obs_t bubble_of(input obs_t l);
    obs_t b;
    b       = l;
    b.taken = 1'b0;
    b.rw    = 1'b0;
    b.mw    = 1'b0;
    b.mr    = 1'b0;
    b.m2r   = 1'b0;
    b.lm    = 2'b00;
    return b;
  endfunction

  task automatic set_nop();
    reg_dst = 0; reg_write = 0; alu_src = 0; mem_write = 0;
    mem_read = 0; mem_to_reg = 0; branch = 0; lmode = 2'b00;
    alu_op = ALU_ADD;
  endtask

  task automatic randomize_inputs();
    rd1 = $urandom; rd2 = $urandom; ext = $urandom; npc = $urandom;
    rd = 5'($urandom); rt = 5'($urandom);
    reg_dst = 1'($urandom_range(0, 1)); reg_write = 1'($urandom_range(0, 1));
    alu_src = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
    mem_read = 1'($urandom_range(0, 1)); mem_to_reg = 1'($urandom_range(0, 1));
    branch = 1'($urandom_range(0, 1)); lmode = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; set_nop();
    rd = '0; rt = '0; ext = '0; rd1 = '0; rd2 = '0; npc = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    got = observe(); checks++;
    if (got !== '0) begin fails++; $display("FAIL reset_outputs: got %h required 0", got); end
    checks++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b required 0", stall); end
    rd1 = 32'h0000_00A5; rd2 = 32'h77; reg_dst = 1; rd = 5'd9; reg_write = 1;
    mem_read = 1; lmode = 2'b10; npc = 32'h40; ext = 32'h3; alu_op = ALU_OR;
    sb.push_back(model());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL reset_preload: got %h required %h", got, exp_v); end
    else $display("txn preload alu=%h dest=%0d", got.alu, got.dest);
    #3; rst = 1'b1; #1;
    got = observe(); checks++;
    if (got !== '0) begin fails++; $display("FAIL reset_async: got %h required 0", got); end
    checks++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_async_stall: got %b required 0", stall); end
    else $display("txn async reset outputs cleared");
    @(posedge clk); #1;
    rst = 1'b0; last_commit = '0; set_nop();
  endtask

  task automatic test_add();
    set_nop();
    rd1 = 32'h5; alu_src = 1; ext = 32'hFFFF_FFFE; alu_op = ALU_ADD;
    reg_dst = 0; rt = 5'd7; rd = 5'd12; reg_write = 1; rd2 = 32'h9;
    sb.push_back(model());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL add_txn: got %h required %h", got, exp_v); end
    else $display("txn add alu=%h dest=%0d", got.alu, got.dest);
    checks++;
    if (alu_result !== 32'h3) begin fails++; $display("FAIL add_result: got %h required 00000003", alu_result); end
    checks++;
    if (dest_reg !== 5'd7) begin fails++; $display("FAIL add_dest: got %0d required 7", dest_reg); end
    last_commit = exp_v;
  endtask

  task automatic test_alu_ops();
    for (int op = 0; op < 7; op++) begin
      for (int k = 0; k < 3; k++) begin
        randomize_inputs();
        alu_op = 3'(op);
        if (k == 0) begin
          // Sign boundary: most negative vs +1 separates signed from unsigned slt.
          rd1 = 32'h8000_0000; rd2 = 32'h1; alu_src = 0;
        end
        sb.push_back(model());
        @(posedge clk); #1;
        exp_v = sb.pop_front(); got = observe(); checks++;
        if (got !== exp_v) begin fails++; $display("FAIL alu_op%0d: got %h required %h", op, got, exp_v); end
        else $display("txn op%0d alu=%h", op, got.alu);
        last_commit = exp_v;
      end
    end
    set_nop();
  endtask

  task automatic test_branch();
    set_nop();
    rd1 = 32'h12; rd2 = 32'h12; alu_src = 0; alu_op = ALU_SUB; branch = 1;
    npc = 32'h100; ext = 32'h4;
    sb.push_back(model());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL branch_txn: got %h required %h", got, exp_v); end
    else $display("txn branch taken=%b target=%h", got.taken, got.bt);
    checks++;
    if (branch_taken !== 1'b1 || branch_target !== 32'h110) begin
      fails++; $display("FAIL branch_taken: got %b/%h required 1/00000110", branch_taken, branch_target);
    end
    last_commit = exp_v;
    rd2 = 32'h13;
    sb.push_back(model());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v || branch_taken !== 1'b0) begin
      fails++; $display("FAIL branch_not_taken: got %h required %h", got, exp_v);
    end else $display("txn branch taken=%b", got.taken);
    last_commit = exp_v;
    set_nop();
  endtask

  task automatic test_mul();
    obs_t bub;
    int   n_stall;
    bit   reached;
    set_nop();
    rd1 = 32'h1234; rd2 = 32'h10; alu_src = 0; alu_op = ALU_MUL; reg_write = 1;
    reg_dst = 1; rd = 5'd3; npc = 32'h200; ext = 32'h0;
    sb.push_back(model());
    #1; checks++;
    if (stall !== 1'b1) begin fails++; $display("FAIL mul_accept_stall: got %b required 1", stall); end
    n_stall = 1; reached = 0;
    bub = bubble_of(last_commit);
    for (int i = 0; i < DW + 8; i++) begin
      @(posedge clk); #1;
      got = observe(); checks++;
      if (got !== bub) begin fails++; $display("FAIL mul_bubble%0d: got %h required %h", i, got, bub); end
      if (!stall) begin reached = 1; break; end
      n_stall++;
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL mul_timeout: stall still 1 after %0d cycles, required drop", DW + 8); end
    checks++;
    if (n_stall != DW + 1) begin fails++; $display("FAIL mul_stall_len: got %0d required %0d", n_stall, DW + 1); end
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL mul_txn: got %h required %h", got, exp_v); end
    else $display("txn mul alu=%h stall_cycles=%0d", got.alu, n_stall);
    checks++;
    if (alu_result !== 32'h0001_2340 || RegWrite !== 1'b1) begin
      fails++; $display("FAIL mul_result: got %h/%b required 00012340/1", alu_result, RegWrite);
    end
    last_commit = exp_v;
    set_nop();
  endtask

  task automatic test_flush();
    bit reached;
    // Flush a single-cycle op.
    set_nop(); rd1 = 32'h11; rd2 = 32'h22; alu_op = ALU_ADD; reg_write = 1; mem_write = 1; flush = 1;
    @(posedge clk); #1;
    got = observe(); checks++;
    if (got !== bubble_of(last_commit)) begin fails++; $display("FAIL flush_single: got %h required %h", got, bubble_of(last_commit)); end
    else $display("txn flush single-cycle bubble");
    // Flush beats mul acceptance.
    alu_op = ALU_MUL; #1; checks++;
    if (stall !== 1'b0) begin fails++; $display("FAIL flush_accept_stall: got %b required 0", stall); end
    @(posedge clk); #1;
    got = observe(); checks++;
    if (got !== bubble_of(last_commit)) begin fails++; $display("FAIL flush_accept: got %h required %h", got, bubble_of(last_commit)); end
    // Flush at BUSY step 10.
    flush = 0; rd1 = 32'hDEAD; rd2 = 32'h7;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1; checks++;
    if (stall !== 1'b1) begin fails++; $display("FAIL flush_busy_stall: got %b required 1", stall); end
    flush = 1; set_nop();
    @(posedge clk); #1;
    flush = 0;
    got = observe(); checks++;
    if (got !== bubble_of(last_commit)) begin fails++; $display("FAIL flush_busy: got %h required %h", got, bubble_of(last_commit)); end
    else $display("txn flush mid-multiply bubble");
    checks++;
    if (stall !== 1'b0) begin fails++; $display("FAIL flush_busy_release: got %b required 0", stall); end
    sb.push_back(model());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL flush_recover: got %h required %h", got, exp_v); end
    last_commit = exp_v;
    // Flush beats DONE commit.
    rd1 = 32'h3; rd2 = 32'h5; alu_src = 0; alu_op = ALU_MUL; reg_write = 1; mem_to_reg = 1;
    reached = 0;
    for (int i = 0; i < DW + 8; i++) begin
      @(posedge clk); #1;
      if (!stall) begin reached = 1; break; end
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL flush_done_timeout: stall still 1, required drop"); end
    flush = 1; set_nop();
    @(posedge clk); #1;
    flush = 0;
    got = observe(); checks++;
    if (got !== bubble_of(last_commit)) begin fails++; $display("FAIL flush_done: got %h required %h", got, bubble_of(last_commit)); end
    else $display("txn flush in DONE bubble");
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [9];
    bit reached;
    ops = '{ALU_ADD, ALU_MUL, ALU_SUB, ALU_MUL, ALU_MUL, ALU_OR, ALU_SLL, ALU_MUL, ALU_NOR};
    foreach (ops[j]) begin
      randomize_inputs();
      alu_op = ops[j];
      sb.push_back(model());
      if (alu_op == ALU_MUL) begin
        reached = 0;
        for (int i = 0; i < DW + 8; i++) begin
          @(posedge clk); #1;
          if (!stall) begin reached = 1; break; end
        end
        checks++;
        if (!reached) begin fails++; $display("FAIL b2b_timeout%0d: stall still 1, required drop", j); end
      end
      @(posedge clk); #1;
      exp_v = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_v) begin fails++; $display("FAIL b2b_txn%0d: got %h required %h", j, got, exp_v); end
      else $display("txn b2b%0d op=%0d alu=%h", j, ops[j], got.alu);
      last_commit = exp_v;
    end
    set_nop();
  endtask

`ifdef EX_OVF_TRAP_EN
  task automatic test_ovf();
    set_nop();
    rd1 = 32'h7FFF_FFFF; alu_src = 1; ext = 32'h1; alu_op = ALU_ADD; reg_write = 1; rt = 5'd4;
    sb.push_back(model());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL ovf_txn: got %h required %h", got, exp_v); end
    checks++;
    if (ovf !== 1'b1 || RegWrite !== 1'b0 || alu_result !== 32'h8000_0000) begin
      fails++; $display("FAIL ovf_trap: got %b/%b/%h required 1/0/80000000", ovf, RegWrite, alu_result);
    end else $display("txn ovf trap alu=%h", alu_result);
    last_commit = exp_v;
    rd1 = 32'h1;
    sb.push_back(model());
    @(posedge clk); #1;
    exp_v = sb.pop_front(); got = observe(); checks++;
    if (got !== exp_v || ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %h/%b required %h/0", got, ovf, exp_v); end
    last_commit = exp_v;
    set_nop();
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    last_commit = '0;
    rst = 1'b1;
    flush = 1'b0;
    set_nop();
    test_reset();
    test_add();
    test_alu_ops();
    test_branch();
    test_mul();
    test_flush();
    test_back_to_back();
`ifdef EX_OVF_TRAP_EN
    test_ovf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
